// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus: responder FSM states,
// command opcodes and the microsecond-to-cycle conversion.
package lcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_COMMIT
  } responder_state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  function automatic int unsigned us_to_cycles(input int unsigned freq,
                                               input int unsigned us);
    return freq / 1000000 * us;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Multi-stage synchronizer for the LCD bus pins plus rise/fall detection
// on the enable strobe, which rides in the MSB of the vector.
module lcd_bus_sync #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-2:0] sync,
  output logic             rise,
  output logic             fall
);

  logic [STAGES-1:0][WIDTH-1:0] stage;
  logic                         e_prev;
  logic                         e_now;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage  <= '0;
      e_prev <= 1'b0;
    end else begin
      stage  <= {stage[STAGES-2:0], bus};
      e_prev <= stage[STAGES-1][WIDTH-1];
    end
  end

  assign e_now = stage[STAGES-1][WIDTH-1];
  assign sync  = stage[STAGES-1][WIDTH-2:0];
  assign rise  = e_now & ~e_prev;
  assign fall  = ~e_now & e_prev;

endmodule

// File: rtl/lcd_responder.sv
// Display end of the 4-pin HD44780 bus: assembles nibbles into bytes,
// models the busy flag and address counter, and answers busy-flag reads.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int unsigned FREQ        = 50000000,
  parameter int unsigned BUSY_US     = 40,
  parameter int unsigned CLEAR_US    = 1640,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [3:0] LCD_D_IN,
  output logic [3:0] LCD_D_OUT,
  output logic       LCD_D_OE,
  output logic       byte_valid,
  output logic       byte_rs,
  output logic [7:0] byte_data,
  output logic       byte_overrun,
  output logic       busy,
  output logic       mode4bit,
  output logic [6:0] addr
);

  localparam int unsigned BUSY_CYC  = us_to_cycles(FREQ, BUSY_US);
  localparam int unsigned CLEAR_CYC = us_to_cycles(FREQ, CLEAR_US);
  localparam logic [20:0] BUSY_LOAD  = 21'(BUSY_CYC);
  localparam logic [20:0] CLEAR_LOAD = 21'(CLEAR_CYC);

  logic [5:0]       bus_sync;
  logic             e_rise;
  logic             e_fall;
  logic             s_rs;
  logic             s_rw;
  logic [3:0]       s_d;

  responder_state_t state;
  logic             rs_cap;
  logic             rw_cap;
  logic             phase_high;
  logic             inc;
  logic [3:0]       nib;
  logic [3:0]       hi_store;
  logic [20:0]      busy_cnt;

  logic             asm_done;
  logic [7:0]       asm_byte;
  logic [3:0]       rd_next;
  logic             long_cmd;

  lcd_bus_sync #(
    .WIDTH (7),
    .STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk  (CLK),
    .rst_n(RST_N),
    .bus  ({LCD_E, LCD_RS, LCD_RW, LCD_D_IN}),
    .sync (bus_sync),
    .rise (e_rise),
    .fall (e_fall)
  );

  assign s_rs = bus_sync[5];
  assign s_rw = bus_sync[4];
  assign s_d  = bus_sync[3:0];

  always_comb begin
    asm_done = 1'b0;
    asm_byte = '0;
    if (!mode4bit) begin
      asm_done = 1'b1;
      asm_byte = {nib, 4'h0};
    end else if (!phase_high) begin
      asm_done = 1'b1;
      asm_byte = {hi_store, nib};
    end
    long_cmd = !rs_cap && (asm_byte == CMD_CLEAR || (asm_byte & 8'hFE) == CMD_HOME);
    rd_next = '0;
    if (!s_rs) rd_next = (mode4bit && !phase_high) ? addr[3:0] : {busy, addr[6:4]};
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      rs_cap       <= 1'b0;
      rw_cap       <= 1'b0;
      phase_high   <= 1'b1;
      inc          <= 1'b1;
      nib          <= '0;
      hi_store     <= '0;
      busy_cnt     <= '0;
      LCD_D_OUT    <= '0;
      LCD_D_OE     <= 1'b0;
      byte_valid   <= 1'b0;
      byte_rs      <= 1'b0;
      byte_data    <= '0;
      byte_overrun <= 1'b0;
      busy         <= 1'b0;
      mode4bit     <= 1'b0;
      addr         <= '0;
    end else begin
      byte_valid   <= 1'b0;
      byte_overrun <= 1'b0;
      if (busy) begin
        busy_cnt <= busy_cnt - 21'd1;
        if (busy_cnt == 21'd1) busy <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (e_rise) begin
            rs_cap <= s_rs;
            rw_cap <= s_rw;
            if (s_rw) begin
              LCD_D_OUT <= rd_next;
              LCD_D_OE  <= 1'b1;
            end
            state <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (e_fall) begin
            if (rw_cap) begin
              LCD_D_OE  <= 1'b0;
              LCD_D_OUT <= '0;
              if (mode4bit) phase_high <= ~phase_high;
              state <= S_IDLE;
            end else begin
              nib   <= s_d;
              state <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          state <= S_IDLE;
          if (mode4bit) phase_high <= ~phase_high;
          if (mode4bit && phase_high) hi_store <= nib;
          // The phase still advances on an overrun; only byte effects are dropped.
          if (asm_done) begin
            if (busy) begin
              byte_overrun <= 1'b1;
            end else begin
              byte_valid <= 1'b1;
              byte_rs    <= rs_cap;
              byte_data  <= asm_byte;
              busy       <= 1'b1;
              busy_cnt   <= long_cmd ? CLEAR_LOAD : BUSY_LOAD;
              if (rs_cap) begin
                addr <= inc ? addr + 7'd1 : addr - 7'd1;
              end else if ((asm_byte & CMD_DDRAM) == CMD_DDRAM) begin
                addr <= asm_byte[6:0];
              end else if ((asm_byte & 8'hE0) == CMD_FUNC) begin
                mode4bit <= ~asm_byte[4];
                if (mode4bit == asm_byte[4]) phase_high <= 1'b1;
              end else if ((asm_byte & 8'hFC) == CMD_ENTRY) begin
                inc <= asm_byte[1];
              end else if ((asm_byte & 8'hFE) == CMD_HOME) begin
                addr <= '0;
              end else if (asm_byte == CMD_CLEAR) begin
                addr <= '0;
                inc  <= 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_responder.sv
// Directed self-checking bench for lcd_responder at FREQ = 1 MHz
// (40-cycle ordinary busy, 1640-cycle clear/home busy).
module tb_lcd_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       e = 1'b0;
  logic       rs = 1'b0;
  logic       rw = 1'b0;
  logic [3:0] din = '0;
  logic [3:0] d_out;
  logic       d_oe;
  logic       byte_valid;
  logic       byte_rs;
  logic [7:0] byte_data;
  logic       byte_overrun;
  logic       busy;
  logic       mode4bit;
  logic [6:0] addr;

  int checks = 0;
  int errors = 0;

  int         vcount = 0;
  int         ocount = 0;
  logic [7:0] last_data = '0;
  logic       last_rs = 1'b0;
  int         busy_run = 0;
  int         busy_len = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [6:0] exp_addr;
    int         exp_len;
  } vec_t;

  vec_t vecs[7];

  lcd_responder #(
    .FREQ       (1000000),
    .BUSY_US    (40),
    .CLEAR_US   (1640),
    .SYNC_STAGES(2)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .LCD_E       (e),
    .LCD_RS      (rs),
    .LCD_RW      (rw),
    .LCD_D_IN    (din),
    .LCD_D_OUT   (d_out),
    .LCD_D_OE    (d_oe),
    .byte_valid  (byte_valid),
    .byte_rs     (byte_rs),
    .byte_data   (byte_data),
    .byte_overrun(byte_overrun),
    .busy        (busy),
    .mode4bit    (mode4bit),
    .addr        (addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) begin
      vcount++;
      last_data = byte_data;
      last_rs   = byte_rs;
    end
    if (byte_overrun) ocount++;
    if (busy) begin
      busy_run++;
    end else begin
      if (busy_run != 0) busy_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic s_rs, input logic s_rw, input logic [3:0] nib,
                        output logic [3:0] rd, output logic oe_hi);
    rs  = s_rs;
    rw  = s_rw;
    din = s_rw ? 4'h0 : nib;
    repeat (2) @(negedge clk);
    e = 1'b1;
    repeat (6) @(negedge clk);
    rd    = d_out;
    oe_hi = d_oe;
    e = 1'b0;
    repeat (6) @(negedge clk);
    rw = 1'b0;
  endtask

  task automatic write_byte(input logic s_rs, input logic [7:0] b);
    logic [3:0] rd;
    logic       oe;
    strobe(s_rs, 1'b0, b[7:4], rd, oe);
    strobe(s_rs, 1'b0, b[3:0], rd, oe);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rd;
    logic       oe;
    int         v0;
    int         o0;

    vecs[0] = '{rs: 1'b0, data: 8'h85, exp_addr: 7'h05, exp_len: 40};
    vecs[1] = '{rs: 1'b1, data: 8'h41, exp_addr: 7'h06, exp_len: 40};
    vecs[2] = '{rs: 1'b0, data: 8'h06, exp_addr: 7'h06, exp_len: 40};
    vecs[3] = '{rs: 1'b1, data: 8'h42, exp_addr: 7'h07, exp_len: 40};
    vecs[4] = '{rs: 1'b0, data: 8'h02, exp_addr: 7'h00, exp_len: 1640};
    vecs[5] = '{rs: 1'b0, data: 8'h90, exp_addr: 7'h10, exp_len: 40};
    vecs[6] = '{rs: 1'b0, data: 8'h28, exp_addr: 7'h10, exp_len: 40};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", addr, 7'h00);
    check("rst_mode", mode4bit, 1'b0);
    check("rst_oe", d_oe, 1'b0);
    check("rst_valid", byte_valid, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8-bit function set -> 4-bit mode
    v0 = vcount;
    strobe(1'b0, 1'b0, 4'h2, rd, oe);
    check("t1_count", vcount, v0 + 1);
    check("t1_data", last_data, 8'h20);
    check("t1_mode", mode4bit, 1'b1);
    check("t1_busy", busy, 1'b1);
    wait_idle("t1_idle");
    check("t1_len", busy_len, 40);

    // Table of 4-bit byte writes
    for (int unsigned i = 0; i < 7; i++) begin
      v0 = vcount;
      write_byte(vecs[i].rs, vecs[i].data);
      check($sformatf("vec%0d_count", i), vcount, v0 + 1);
      check($sformatf("vec%0d_data", i), last_data, vecs[i].data);
      check($sformatf("vec%0d_rs", i), last_rs, vecs[i].rs);
      check($sformatf("vec%0d_addr", i), addr, vecs[i].exp_addr);
      wait_idle($sformatf("vec%0d_idle", i));
      check($sformatf("vec%0d_len", i), busy_len, vecs[i].exp_len);
    end
    check("t2_mode", mode4bit, 1'b1);

    // Clear, then busy-flag reads during the long busy
    v0 = vcount;
    write_byte(1'b0, 8'h01);
    check("t3_count", vcount, v0 + 1);
    check("t3_data", last_data, 8'h01);
    check("t3_addr", addr, 7'h00);
    check("t3_busy", busy, 1'b1);
    strobe(1'b0, 1'b1, 4'h0, rd, oe);
    check("t3_rd1", rd, 4'h8);
    check("t3_oe1", oe, 1'b1);
    check("t3_oe1_after", d_oe, 1'b0);
    strobe(1'b0, 1'b1, 4'h0, rd, oe);
    check("t3_rd2", rd, 4'h0);
    check("t3_oe2", oe, 1'b1);
    check("t3_oe2_after", d_oe, 1'b0);

    // Write while still busy from the clear
    v0 = vcount;
    o0 = ocount;
    write_byte(1'b0, 8'hB3);
    check("t4_overrun", ocount, o0 + 1);
    check("t4_novalid", vcount, v0);
    check("t4_addr", addr, 7'h00);
    check("t4_busy", busy, 1'b1);
    wait_idle("t4_idle");
    check("t4_len", busy_len, 1640);

    // Address wrap in both directions
    write_byte(1'b0, 8'hFF);
    check("t5_set7f", addr, 7'h7F);
    wait_idle("t5_idle1");
    write_byte(1'b1, 8'h41);
    check("t5_wrap_up", addr, 7'h00);
    wait_idle("t5_idle2");
    write_byte(1'b0, 8'h04);
    check("t5_entry_addr", addr, 7'h00);
    wait_idle("t5_idle3");
    write_byte(1'b1, 8'h41);
    check("t5_wrap_down", addr, 7'h7F);
    wait_idle("t5_idle4");

    // Reset between the two halves of a 4-bit write
    strobe(1'b1, 1'b0, 4'h4, rd, oe);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v0 = vcount;
    check("t6_mode", mode4bit, 1'b0);
    check("t6_oe", d_oe, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_addr", addr, 7'h00);
    check("t6_data", byte_data, 8'h00);
    strobe(1'b0, 1'b0, 4'h2, rd, oe);
    check("t6_count", vcount, v0 + 1);
    check("t6_byte", last_data, 8'h20);
    check("t6_mode4", mode4bit, 1'b1);
    wait_idle("t6_idle");
    write_byte(1'b1, 8'h55);
    check("t6_byte2", last_data, 8'h55);
    check("t6_addr2", addr, 7'h01);
    wait_idle("t6_idle2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
